// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg                                                          |
// | Shared encodings for the unified memory arbiter.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

    localparam int unsigned c_state_w = 2;
    localparam logic [c_state_w-1:0] c_st_idle = 2'd0;
    localparam logic [c_state_w-1:0] c_st_req  = 2'd1;
    localparam logic [c_state_w-1:0] c_st_resp = 2'd2;

    localparam logic c_own_im = 1'b0;
    localparam logic c_own_dm = 1'b1;

    // Wide enough for any supported data width; users slice the low bits.
    localparam int unsigned c_max_be_w = 128;
    localparam logic [c_max_be_w-1:0] c_fetch_be = '1;

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unified_mem_arbiter_if                                               |
// | Fetch, data and memory-bus signals of the unified arbiter.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    localparam int BE_W = DATA_W / 8;

    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_gnt;
    logic              im_rvalid;
    logic [DATA_W-1:0] im_rdata;

    logic              dm_req;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_we;
    logic [BE_W-1:0]   dm_be;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_we;
    logic [BE_W-1:0]   bus_be;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_err;

    modport slave (
        input  im_req, im_addr,
        output im_gnt, im_rvalid, im_rdata,
        input  dm_req, dm_addr, dm_wdata, dm_we, dm_be,
        output dm_gnt, dm_rvalid, dm_rdata,
        output bus_req, bus_addr, bus_wdata, bus_we, bus_be, bus_err,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport master (
        output im_req, im_addr,
        input  im_gnt, im_rvalid, im_rdata,
        output dm_req, dm_addr, dm_wdata, dm_we, dm_be,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  bus_req, bus_addr, bus_wdata, bus_we, bus_be, bus_err,
        output bus_gnt, bus_rvalid, bus_rdata
    );

endinterface
`default_nettype wire

// File: rtl/unified_mem_arbiter_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_prio                                                         |
// | Data-first priority with a bounded fetch-starvation counter.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_arb_en,
    input  wire logic i_im_req,
    input  wire logic i_dm_req,
    output logic      o_valid,
    output logic      o_win
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_cnt_nxt;
    logic             w_im_turn;

    assign w_im_turn = i_im_req && (r_starve_cnt == c_starve_max);
    assign o_valid   = i_arb_en && (i_im_req || i_dm_req);
    assign o_win     = (i_dm_req && !w_im_turn) ? c_own_dm : c_own_im;

    // Counts data wins only while fetch is actually waiting.
    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (!i_im_req) begin
            w_starve_cnt_nxt = '0;
        end else if (o_valid) begin
            if (o_win == c_own_im) begin
                w_starve_cnt_nxt = '0;
            end else if (r_starve_cnt != c_starve_max) begin
                w_starve_cnt_nxt = r_starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unified_mem_arbiter                                                  |
// | Shares one memory bus between fetch and data, one txn at a time.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    unified_mem_arbiter_if.slave mem
);
    localparam int BE_W = DATA_W / 8;

    logic [c_state_w-1:0] r_state, w_state_nxt;
    logic                 r_owner, w_owner_nxt;
    logic [ADDR_W-1:0]    r_addr,  w_addr_nxt;
    logic [DATA_W-1:0]    r_wdata, w_wdata_nxt;
    logic                 r_we,    w_we_nxt;
    logic [BE_W-1:0]      r_be,    w_be_nxt;
    logic                 r_err,   w_err_nxt;
    logic                 w_arb_en;
    logic                 w_arb_valid;
    logic                 w_win;
    logic                 w_resp_done;

    // rst_n gates arbitration so no grant can leak out while held in reset.
    assign w_arb_en    = (r_state == c_st_idle) && rst_n;
    assign w_resp_done = (r_state == c_st_resp) && mem.bus_rvalid;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_arb_en (w_arb_en),
        .i_im_req (mem.im_req),
        .i_dm_req (mem.dm_req),
        .o_valid  (w_arb_valid),
        .o_win    (w_win)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_we_nxt    = r_we;
        w_be_nxt    = r_be;
        w_err_nxt   = r_err || (mem.bus_rvalid && (r_state != c_st_resp));
        case (r_state)
            c_st_idle: begin
                if (w_arb_valid) begin
                    w_state_nxt = c_st_req;
                    w_owner_nxt = w_win;
                    if (w_win == c_own_dm) begin
                        w_addr_nxt  = mem.dm_addr;
                        w_wdata_nxt = mem.dm_wdata;
                        w_we_nxt    = mem.dm_we;
                        w_be_nxt    = mem.dm_be;
                    end else begin
                        w_addr_nxt  = mem.im_addr;
                        w_wdata_nxt = '0;
                        w_we_nxt    = 1'b0;
                        w_be_nxt    = c_fetch_be[BE_W-1:0];
                    end
                end
            end
            c_st_req: begin
                if (mem.bus_gnt) begin
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: begin
                if (mem.bus_rvalid) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_owner <= c_own_dm;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_we    <= w_we_nxt;
            r_be    <= w_be_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign mem.im_gnt    = w_arb_valid && (w_win == c_own_im);
    assign mem.dm_gnt    = w_arb_valid && (w_win == c_own_dm);
    assign mem.im_rvalid = w_resp_done && (r_owner == c_own_im);
    assign mem.dm_rvalid = w_resp_done && (r_owner == c_own_dm);
    assign mem.im_rdata  = mem.bus_rdata;
    assign mem.dm_rdata  = mem.bus_rdata;

    assign mem.bus_req   = (r_state == c_st_req);
    assign mem.bus_addr  = r_addr;
    assign mem.bus_wdata = r_wdata;
    assign mem.bus_we    = r_we;
    assign mem.bus_be    = r_be;
    assign mem.bus_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_unified_mem_arbiter                                               |
// | Scoreboard bench: directed transactions against a memory responder.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct { logic own; logic [31:0] addr; logic [31:0] wdata; logic we; logic [3:0] be; } bus_exp_t;
    typedef struct { int gw; int rw; logic [31:0] rdata; } mem_cmd_t;
    typedef struct { logic own; logic [31:0] data; int lat; } resp_exp_t;

    logic      clk         = 1'b0;
    logic      rst_n       = 1'b0;
    logic      inject_spur = 1'b0;
    int        n_checks    = 0;
    int        n_fail      = 0;
    int        cyc         = 0;
    int        gnt_cyc     = 0;
    logic      q_gnt[$];
    bus_exp_t  q_bus[$];
    mem_cmd_t  q_mem[$];
    resp_exp_t q_resp[$];

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    unified_mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (mif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_txn(input logic own, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic we, input logic [3:0] be, input int gw, input int rw,
                              input logic [31:0] rdata, input logic has_resp, input int lat);
        bus_exp_t  b;
        mem_cmd_t  m;
        resp_exp_t r;
        q_gnt.push_back(own);
        b.own = own; b.addr = addr; b.wdata = wdata; b.we = we; b.be = be;
        q_bus.push_back(b);
        m.gw = gw; m.rw = rw; m.rdata = rdata;
        q_mem.push_back(m);
        if (has_resp) begin
            r.own = own; r.data = rdata; r.lat = lat;
            q_resp.push_back(r);
        end
    endtask

    task automatic issue(input logic own, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [3:0] be);
        logic got;
        @(posedge clk); #1;
        if (own == c_own_dm) begin
            mif.dm_req = 1'b1; mif.dm_addr = addr; mif.dm_wdata = wdata; mif.dm_we = we; mif.dm_be = be;
        end else begin
            mif.im_req = 1'b1; mif.im_addr = addr;
        end
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = (own == c_own_dm) ? mif.dm_gnt : mif.im_gnt;
        end
        check("gnt_wait", 64'(got), 64'd1);
        @(posedge clk); #1;
        // Scramble request fields: the latched transaction must not follow them.
        mif.im_req = 1'b0; mif.dm_req = 1'b0;
        mif.im_addr = 32'hFFFF_FFF0; mif.dm_addr = 32'hEEEE_EEE0;
        mif.dm_wdata = 32'hBAD0_BAD0; mif.dm_we = ~we; mif.dm_be = 4'hA;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q_resp.size() != 0 || q_gnt.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain_in_time", 64'(k < 200), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_im_gnt",    64'(mif.im_gnt),    64'd0);
        check("rst_dm_gnt",    64'(mif.dm_gnt),    64'd0);
        check("rst_im_rvalid", 64'(mif.im_rvalid), 64'd0);
        check("rst_dm_rvalid", 64'(mif.dm_rvalid), 64'd0);
        check("rst_bus_req",   64'(mif.bus_req),   64'd0);
        check("rst_bus_addr",  64'(mif.bus_addr),  64'd0);
        check("rst_bus_wdata", 64'(mif.bus_wdata), 64'd0);
        check("rst_bus_we",    64'(mif.bus_we),    64'd0);
        check("rst_bus_be",    64'(mif.bus_be),    64'd0);
        check("rst_bus_err",   64'(mif.bus_err),   64'd0);
    endtask

    // Memory responder: waits gw cycles before bus_gnt, then rw cycles before bus_rvalid.
    initial begin : responder
        int       phase;
        int       cnt;
        mem_cmd_t cur;
        phase = 0; cnt = 0;
        cur.gw = 0; cur.rw = 0; cur.rdata = '0;
        mif.bus_gnt = 1'b0; mif.bus_rvalid = 1'b0; mif.bus_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mif.bus_gnt = 1'b0;
            mif.bus_rvalid = 1'b0;
            if (!rst_n) begin
                phase = 0;
            end else if (phase == 2) begin
                if (cnt == 0) begin
                    mif.bus_rvalid = 1'b1; mif.bus_rdata = cur.rdata; phase = 0;
                end else begin
                    cnt--;
                end
            end else if (phase == 1 || mif.bus_req) begin
                if (phase == 0) begin
                    check("mem_cmd_available", 64'(q_mem.size() != 0), 64'd1);
                    if (q_mem.size() != 0) begin
                        cur = q_mem.pop_front(); cnt = cur.gw; phase = 1;
                    end
                end
                if (phase == 1) begin
                    if (cnt == 0) begin
                        mif.bus_gnt = 1'b1; phase = 2; cnt = cur.rw;
                    end else begin
                        cnt--;
                    end
                end
            end else if (inject_spur) begin
                mif.bus_rvalid = 1'b1; mif.bus_rdata = 32'h5A5A_5A5A; inject_spur = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin : monitor
        bus_exp_t  b;
        resp_exp_t r;
        logic      og;
        if (mif.im_gnt || mif.dm_gnt) begin
            check("gnt_onehot", 64'(mif.im_gnt & mif.dm_gnt), 64'd0);
            check("gnt_expected", 64'(q_gnt.size() != 0), 64'd1);
            if (q_gnt.size() != 0) begin
                og = q_gnt.pop_front();
                check("gnt_owner", 64'(mif.dm_gnt), 64'(og));
                gnt_cyc = cyc;
            end
        end
        if (mif.bus_req) begin
            check("bus_req_expected", 64'(q_bus.size() != 0), 64'd1);
            if (q_bus.size() != 0) begin
                b = q_bus[0];
                check("bus_addr", 64'(mif.bus_addr), 64'(b.addr));
                check("bus_we",   64'(mif.bus_we),   64'(b.we));
                check("bus_be",   64'(mif.bus_be),   64'(b.be));
                if (b.own == c_own_dm) check("bus_wdata", 64'(mif.bus_wdata), 64'(b.wdata));
                if (mif.bus_gnt) b = q_bus.pop_front();
            end
        end
        if (mif.im_rvalid || mif.dm_rvalid) begin
            check("rvalid_onehot", 64'(mif.im_rvalid & mif.dm_rvalid), 64'd0);
            check("resp_expected", 64'(q_resp.size() != 0), 64'd1);
            if (q_resp.size() != 0) begin
                r = q_resp.pop_front();
                check("rvalid_owner", 64'(mif.dm_rvalid), 64'(r.own));
                check("rdata", 64'((r.own == c_own_dm) ? mif.dm_rdata : mif.im_rdata), 64'(r.data));
                check("latency", 64'(cyc - gnt_cyc), 64'(r.lat));
            end
        end
    end

    initial begin : watchdog
        #20000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [9:0] seq;
        logic       got;
        int         k;
        mif.im_req = 1'b0; mif.im_addr = '0;
        mif.dm_req = 1'b0; mif.dm_addr = '0; mif.dm_wdata = '0; mif.dm_we = 1'b0; mif.dm_be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single fetch, minimum latency.
        expect_txn(c_own_im, 32'h100, 32'h0, 1'b0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b1, 2);
        issue(c_own_im, 32'h100, 32'h0, 1'b0, 4'h0);
        drain();

        // Store with three bus_gnt wait cycles.
        expect_txn(c_own_dm, 32'h2000, 32'h1234, 1'b1, 4'h3, 3, 0, 32'hCAFE_0001, 1'b1, 5);
        issue(c_own_dm, 32'h2000, 32'h1234, 1'b1, 4'h3);
        drain();

        // Load with two bus_rvalid wait cycles.
        expect_txn(c_own_dm, 32'h3004, 32'h0, 1'b0, 4'hF, 0, 2, 32'h0BAD_F00D, 1'b1, 4);
        issue(c_own_dm, 32'h3004, 32'h0, 1'b0, 4'hF);
        drain();

        // Fetch with one wait on each phase.
        expect_txn(c_own_im, 32'h44, 32'h0, 1'b0, 4'hF, 1, 1, 32'h1357_9BDF, 1'b1, 4);
        issue(c_own_im, 32'h44, 32'h0, 1'b0, 4'h0);
        drain();

        // Contention: D,D,D,D,I,D,D,D,D,I (bit set = fetch wins).
        seq = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            if (seq[i])
                expect_txn(c_own_im, 32'h400, 32'h0, 1'b0, 4'hF, 0, 0, 32'h1000_0000 + 32'(i), 1'b1, 2);
            else
                expect_txn(c_own_dm, 32'h800, 32'h55, 1'b1, 4'h5, 0, 0, 32'h1000_0000 + 32'(i), 1'b1, 2);
        end
        @(posedge clk); #1;
        mif.im_req = 1'b1; mif.im_addr = 32'h400;
        mif.dm_req = 1'b1; mif.dm_addr = 32'h800; mif.dm_wdata = 32'h55; mif.dm_we = 1'b1; mif.dm_be = 4'h5;
        k = 0;
        while (q_gnt.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("contention_in_time", 64'(k < 200), 64'd1);
        @(posedge clk); #1;
        mif.im_req = 1'b0; mif.dm_req = 1'b0;
        drain();

        // Spurious bus_rvalid while idle.
        @(negedge clk);
        check("err_before_spur", 64'(mif.bus_err), 64'd0);
        inject_spur = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("spur_no_rvalid", 64'({mif.im_rvalid, mif.dm_rvalid}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("err_after_spur", 64'(mif.bus_err), 64'd1);
        expect_txn(c_own_im, 32'h80, 32'h0, 1'b0, 4'hF, 0, 0, 32'h2468_ACE0, 1'b1, 2);
        issue(c_own_im, 32'h80, 32'h0, 1'b0, 4'h0);
        drain();
        check("err_sticky", 64'(mif.bus_err), 64'd1);

        // Reset while a data load sits in RESP; the load is lost.
        expect_txn(c_own_dm, 32'h3000, 32'h0, 1'b0, 4'hF, 0, 6, 32'h7777_7777, 1'b0, 0);
        issue(c_own_dm, 32'h3000, 32'h0, 1'b0, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_txn(c_own_im, 32'h200, 32'h0, 1'b0, 4'hF, 0, 0, 32'h600D_CAFE, 1'b1, 2);
        mif.im_req = 1'b1; mif.im_addr = 32'h200;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got = 1'b0;
        for (int j = 0; j < 50 && !got; j++) begin
            @(negedge clk);
            got = mif.im_gnt;
        end
        check("post_reset_gnt", 64'(got), 64'd1);
        @(posedge clk); #1;
        mif.im_req = 1'b0;
        drain();
        check("err_after_reset", 64'(mif.bus_err), 64'd0);

        check("gnt_queue_empty",  64'(q_gnt.size()),  64'd0);
        check("bus_queue_empty",  64'(q_bus.size()),  64'd0);
        check("mem_queue_empty",  64'(q_mem.size()),  64'd0);
        check("resp_queue_empty", 64'(q_resp.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported unified memory bus between the core's instruction-fetch port and data-access port. It sits between the pipeline's imem/dmem interfaces and the external memory. Each access is sequenced as one outstanding request/grant/response transaction at a time. Data accesses have priority, and a bounded-starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables = DATA_W/8)
- STARVE_MAX, 4, consecutive data wins tolerated while fetch waits (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- im_req  in  1  fetch request
- im_addr  in  ADDR_W  fetch address
- im_gnt  out  1  fetch request accepted (one cycle)
- im_rvalid  out  1  fetch data valid
- im_rdata  out  DATA_W  fetch data
- dm_req  in  1  data request
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_we  in  1  1 = store
- dm_be  in  DATA_W/8  byte enables
- dm_gnt  out  1  data request accepted (one cycle)
- dm_rvalid  out  1  load data valid / store acknowledged
- dm_rdata  out  DATA_W  load data
- bus_req  out  1  bus request
- bus_addr / bus_wdata / bus_we / bus_be  out  ADDR_W / DATA_W / 1 / DATA_W/8  latched transaction
- bus_gnt  in  1  memory accepted bus_req
- bus_rvalid  in  1  transaction complete (reads and writes)
- bus_rdata  in  DATA_W  read data
- bus_err  out  1  sticky protocol-error flag

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: arbitrate over im_req/dm_req.
  - Winner's gnt is driven combinationally high in that cycle.
  - At the clock edge, the winner's fields are latched into bus_* and the owner is recorded; go to REQ.
  - With no request, stay in IDLE.
- Priority: dm wins unless starve_cnt == STARVE_MAX and im_req is high.
- starve_cnt increments on each dm grant while im_req is high. It clears on an im grant or whenever im_req is low. It saturates at STARVE_MAX.
- Fetch transactions drive bus_we = 0 and bus_be = all ones.
- REQ: bus_req = 1 with fields stable until bus_gnt is sampled high, then go to RESP.
- RESP: bus_req = 0.
  - When bus_rvalid is high, the owner's rvalid is high that same cycle and rdata = bus_rdata (combinational pass-through); go to IDLE.
  - The non-owner's rvalid stays 0.
- Requesters may drop or change req after their gnt cycle. The latched transaction is unaffected.
- bus_rvalid outside RESP is ignored and sets bus_err. bus_err clears only on reset.
- gnt outputs are 0 outside IDLE and while rst_n is low.
- No abort: a fetch in flight after a pipeline flush completes normally. The core discards the data.

## Timing
- Reset (async assert, sync-safe deassert handled upstream) puts the block in:
  - state IDLE, starve_cnt 0, owner = data
  - bus_req/bus_we/bus_err 0; bus_addr/bus_wdata/bus_be 0
  - im_gnt/dm_gnt/im_rvalid/dm_rvalid 0; rdata outputs follow bus_rdata but are qualified by rvalid
- Minimum transaction: gnt at cycle 0, bus_req at cycle 1; bus_gnt at 1 gives RESP at 2; bus_rvalid at 2 returns data at cycle 2; IDLE at 3.
- Back-to-back throughput is therefore one transaction per 3 cycles minimum.
- Each extra wait cycle on bus_gnt or bus_rvalid adds exactly one cycle.
- Simultaneous im_req and dm_req in IDLE: dm granted, unless the starvation limit is reached.
- Reset asserted mid-transaction: state drops to IDLE immediately and the transaction is lost. The memory is reset by the same rst_n.

## Structure
- Shared package mem_arb_pkg holds:
  - state enum (IDLE/REQ/RESP)
  - owner encoding (OWN_IM/OWN_DM)
  - default fetch byte-enable constant
- Sub-module mem_arb_prio (natural split): priority decision plus starve_cnt. Its outputs are the winner and a valid signal.
- Top level: FSM, transaction latch, response steering, bus_err.

## Test plan
- Single fetch: im_req at cycle 0, addr 0x100, bus_gnt immediate, bus_rvalid at cycle 2 with 0xDEADBEEF → im_gnt at cycle 0, bus_req at cycle 1 with bus_addr 0x100 and bus_be 0xF, im_rvalid at cycle 2 with data 0xDEADBEEF, dm_rvalid 0.
- Store with 3-cycle bus_gnt wait: dm addr 0x2000, wdata 0x1234, be 0x3, we 1 → bus fields stable through all REQ cycles, dm_rvalid on bus_rvalid, bus_we 1.
- Contention: im_req and dm_req held continuously, STARVE_MAX = 4 → grant sequence D,D,D,D,I,D,D,D,D,I…; starve_cnt never exceeds 4.
- Spurious bus_rvalid in IDLE → no rvalid to either port, bus_err = 1 and stays 1 until rst_n is low.
- rst_n dropped during RESP with a pending dm load → all outputs at reset values in the same cycle; after release, a new im_req is granted normally.
